vc_allocator: RTL

Router-wide virtual-channel allocator that serves the VA stage of every input buffer. It takes per-input-VC allocation requests and their computed output ports, and grants each winner a free virtual channel on the downstream router. It tracks which downstream VCs are free; a VC is released when the downstream input buffer pulses its `vc_allocatable` signal. Grants drive each input buffer's `vc_valid_i` and `vc_new_i`.

---
 rtl/vc_allocator.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/vc_allocator.sv
// Router-wide virtual-channel allocator.
// Each output port picks one requester per cycle (round-robin from rr_ptr) and hands it the
// lowest-index free downstream VC. Free/busy state is tracked per downstream VC and restored
// by one-cycle release pulses from the downstream input buffers.
module vc_allocator #(
    parameter int unsigned PORT_NUM = 5,
    parameter int unsigned VC_NUM   = 2,
    parameter int unsigned VC_SIZE  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
    parameter int unsigned PORT_W   = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]             request_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_W-1:0] out_port_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]             idle_downstream_vc_i,
    output logic [PORT_NUM-1:0][VC_NUM-1:0]             vc_valid_o,
    output logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] vc_new_o,
    output logic                                        error_o
);

    localparam int unsigned REQ_NUM = PORT_NUM * VC_NUM;
    localparam int unsigned RR_W    = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    // Registered state
    logic [PORT_NUM-1:0][VC_NUM-1:0] avail_q, avail_d;
    logic [PORT_NUM-1:0][RR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic                            error_q, error_d;

    // Requests flattened to requester index r = port*VC_NUM+vc
    logic [REQ_NUM-1:0]              req_ok;
    logic [REQ_NUM-1:0][PORT_W-1:0]  req_port;
    logic                            bad_port;

    // Per-output-port arbitration results
    logic [PORT_NUM-1:0]              win_found;
    logic [PORT_NUM-1:0][RR_W-1:0]    win_idx;
    logic [PORT_NUM-1:0]              vc_found;
    logic [PORT_NUM-1:0][VC_SIZE-1:0] vc_sel;
    logic [PORT_NUM-1:0]              grant;

    // Flatten requests; a request naming a nonexistent port is dropped and flagged
    always_comb begin
        req_ok   = '0;
        req_port = '0;
        bad_port = 1'b0;
        for (int p = 0; p < int'(PORT_NUM); p++) begin
            for (int v = 0; v < int'(VC_NUM); v++) begin
                req_port[RR_W'(p * int'(VC_NUM) + v)] = out_port_i[p][v];
                if (request_i[p][v]) begin
                    if (32'(out_port_i[p][v]) < PORT_NUM) begin
                        req_ok[RR_W'(p * int'(VC_NUM) + v)] = 1'b1;
                    end else begin
                        bad_port = 1'b1;
                    end
                end
            end
        end
    end

    // Per output port: round-robin winner from rr_ptr upward with wrap, lowest free VC
    always_comb begin
        int idx;
        idx       = 0;
        win_found = '0;
        win_idx   = '0;
        vc_found  = '0;
        vc_sel    = '0;
        grant     = '0;
        for (int p = 0; p < int'(PORT_NUM); p++) begin
            for (int k = 0; k < int'(REQ_NUM); k++) begin
                idx = int'(rr_ptr_q[p]) + k;
                if (idx >= int'(REQ_NUM)) begin
                    idx = idx - int'(REQ_NUM);
                end
                if (!win_found[p] && req_ok[RR_W'(idx)] &&
                    (req_port[RR_W'(idx)] == PORT_W'(p))) begin
                    win_found[p] = 1'b1;
                    win_idx[p]   = RR_W'(idx);
                end
            end
            // Descending scan so the lowest free VC is the last one written
            for (int v = int'(VC_NUM) - 1; v >= 0; v--) begin
                if (avail_q[p][v]) begin
                    vc_found[p] = 1'b1;
                    vc_sel[p]   = VC_SIZE'(v);
                end
            end
            grant[p] = win_found[p] && vc_found[p];
        end
    end

    // Route each port's grant back to the winning requester
    always_comb begin
        logic [RR_W-1:0] r_idx;
        r_idx      = '0;
        vc_valid_o = '0;
        vc_new_o   = '0;
        for (int pr = 0; pr < int'(PORT_NUM); pr++) begin
            for (int vr = 0; vr < int'(VC_NUM); vr++) begin
                r_idx = RR_W'(pr * int'(VC_NUM) + vr);
                for (int p = 0; p < int'(PORT_NUM); p++) begin
                    if (grant[p] && (win_idx[p] == r_idx)) begin
                        vc_valid_o[pr][vr] = 1'b1;
                        vc_new_o[pr][vr]   = vc_sel[p];
                    end
                end
            end
        end
    end

    // Next state: releases set avail, grants clear it and advance the pointer
    always_comb begin
        avail_d  = avail_q;
        rr_ptr_d = rr_ptr_q;
        error_d  = bad_port;
        for (int p = 0; p < int'(PORT_NUM); p++) begin
            for (int v = 0; v < int'(VC_NUM); v++) begin
                if (idle_downstream_vc_i[p][v]) begin
                    if (avail_q[p][v]) begin
                        error_d = 1'b1;
                    end
                    avail_d[p][v] = 1'b1;
                end
            end
        end
        // Applied after releases so a real allocation wins over a spurious release
        for (int p = 0; p < int'(PORT_NUM); p++) begin
            if (grant[p]) begin
                avail_d[p][vc_sel[p]] = 1'b0;
                if (win_idx[p] == RR_W'(REQ_NUM - 1)) begin
                    rr_ptr_d[p] = '0;
                end else begin
                    rr_ptr_d[p] = win_idx[p] + RR_W'(1);
                end
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            avail_q  <= '1;
            rr_ptr_q <= '0;
            error_q  <= 1'b0;
        end else begin
            avail_q  <= avail_d;
            rr_ptr_q <= rr_ptr_d;
            error_q  <= error_d;
        end
    end

    assign error_o = error_q;

endmodule
